// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: sequential PC generation, single-outstanding imem handshake,
// small instruction FIFO feeding IF/ID. Optional IF_PERF_CNT_EN adds fetch/flush counters.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h00000000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] PC_out,
    output logic        fetch_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } state_t;

    state_t          state, state_n;
    logic            req_n;
    logic [31:0]     addr_n;
    logic [31:0]     fetch_pc, fetch_pc_n;
    logic [31:0]     redirect_aligned;

    logic [31:0]     fifo_instr [FIFO_DEPTH];
    logic [31:0]     fifo_pc    [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_n;
    logic            push, pop;

    assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

    // Acks arriving under flush or while draining a dropped request never enter the FIFO.
    assign push    = (state == REQ) && imem_ack && !flush;
    assign pop     = fetch_valid && !stall && !flush;
    assign count_n = flush ? '0 : (count + CW'(push) - CW'(pop));

    always_comb begin
        state_n    = state;
        req_n      = imem_req;
        addr_n     = imem_addr;
        fetch_pc_n = fetch_pc;
        if (flush) begin
            fetch_pc_n = redirect_aligned;
        end
        unique case (state)
            IDLE: begin
                if (!flush && (count < DEPTH_C)) begin
                    state_n = REQ;
                    req_n   = 1'b1;
                    addr_n  = fetch_pc;
                end
            end
            REQ: begin
                if (flush) begin
                    // The outstanding request must still complete; only its data is dropped.
                    if (imem_ack) begin
                        state_n = IDLE;
                        req_n   = 1'b0;
                    end else begin
                        state_n = DROP;
                    end
                end else if (imem_ack) begin
                    fetch_pc_n = fetch_pc + 32'd4;
                    if (count_n < DEPTH_C) begin
                        addr_n = fetch_pc + 32'd4;
                    end else begin
                        state_n = IDLE;
                        req_n   = 1'b0;
                    end
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_n = IDLE;
                    req_n   = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                req_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            fetch_pc  <= RESET_PC;
        end else begin
            state     <= state_n;
            imem_req  <= req_n;
            imem_addr <= addr_n;
            fetch_pc  <= fetch_pc_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                wr_ptr <= wr_ptr + AW'(push);
                rd_ptr <= rd_ptr + AW'(pop);
            end
            count <= count_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= (imem_rdata == 32'h0) ? NOP_INSTR : imem_rdata;
            fifo_pc[wr_ptr]    <= imem_addr;
        end
    end

    always_comb begin
        fetch_valid = (count != '0);
        instr_out   = NOP_INSTR;
        PC_out      = 32'h0;
        if (fetch_valid) begin
            instr_out = fifo_instr[rd_ptr];
            PC_out    = fifo_pc[rd_ptr];
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            fetch_cnt <= fetch_cnt + 32'(push);
            flush_cnt <= flush_cnt + 32'(flush);
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit; memory model returns addr+0x1000
// (or zero at 0x10 when zero_en is set). Perf-counter checks compile under IF_PERF_CNT_EN.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] PC_out;
    logic        fetch_valid;
    logic        zero_en;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        imem_rdata = imem_addr + 32'h1000;
        if (zero_en && (imem_addr == 32'h10)) imem_rdata = 32'h0;
    end

    if_fetch_unit #(
        .RESET_PC  (32'h00000000),
        .FIFO_DEPTH(2),
        .NOP_INSTR (32'h00000013)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .flush      (flush),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr_out  (instr_out),
        .PC_out     (PC_out),
        .fetch_valid(fetch_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt  (fetch_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = '0; imem_ack = 1'b0; zero_en = 1'b0;
        step(); step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %h exp 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
        checks++; if (instr_out !== 32'h13) begin errors++; $display("FAIL rst_instr got %h exp 13", instr_out); end
        checks++; if (PC_out !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", PC_out); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %h exp 0", fetch_valid); end
    endtask

    task automatic test_stream();
        reset = 1'b0; imem_ack = 1'b1;
        step();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL str_req got %h exp 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL str_addr0 got %h exp 0", imem_addr); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL str_valid0 got %h exp 0", fetch_valid); end
        step();
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL str_addr1 got %h exp 4", imem_addr); end
        checks++; if (instr_out !== 32'h1000) begin errors++; $display("FAIL str_instr0 got %h exp 1000", instr_out); end
        checks++; if (PC_out !== 32'h0) begin errors++; $display("FAIL str_pc0 got %h exp 0", PC_out); end
        checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL str_valid1 got %h exp 1", fetch_valid); end
        step();
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL str_addr2 got %h exp 8", imem_addr); end
        checks++; if (instr_out !== 32'h1004) begin errors++; $display("FAIL str_instr1 got %h exp 1004", instr_out); end
        checks++; if (PC_out !== 32'h4) begin errors++; $display("FAIL str_pc1 got %h exp 4", PC_out); end
        step();
        checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL str_addr3 got %h exp c", imem_addr); end
        checks++; if (instr_out !== 32'h1008) begin errors++; $display("FAIL str_instr2 got %h exp 1008", instr_out); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stl_req_drop got %h exp 0", imem_req); end
        checks++; if (PC_out !== 32'h8) begin errors++; $display("FAIL stl_pc_hold0 got %h exp 8", PC_out); end
        step(); step(); step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stl_req_idle got %h exp 0", imem_req); end
        checks++; if (instr_out !== 32'h1008) begin errors++; $display("FAIL stl_instr_hold got %h exp 1008", instr_out); end
        checks++; if (PC_out !== 32'h8) begin errors++; $display("FAIL stl_pc_hold got %h exp 8", PC_out); end
        checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL stl_valid got %h exp 1", fetch_valid); end
        stall = 1'b0;
        step();
        checks++; if (instr_out !== 32'h100C) begin errors++; $display("FAIL stl_instr_next got %h exp 100c", instr_out); end
        checks++; if (PC_out !== 32'hC) begin errors++; $display("FAIL stl_pc_next got %h exp c", PC_out); end
        step();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stl_req_resume got %h exp 1", imem_req); end
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL stl_addr_resume got %h exp 10", imem_addr); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL stl_empty got %h exp 0", fetch_valid); end
    endtask

    task automatic test_zero_word();
        zero_en = 1'b1;
        step();
        checks++; if (instr_out !== 32'h13) begin errors++; $display("FAIL zw_instr got %h exp 13", instr_out); end
        checks++; if (PC_out !== 32'h10) begin errors++; $display("FAIL zw_pc got %h exp 10", PC_out); end
        checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL zw_valid got %h exp 1", fetch_valid); end
        zero_en = 1'b0;
    endtask

    task automatic test_flush_pending();
        reset = 1'b1; imem_ack = 1'b0;
        step();
        reset = 1'b0; imem_ack = 1'b1;
        step(); step(); step();
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL fp_addr_pre got %h exp 8", imem_addr); end
        imem_ack = 1'b0; flush = 1'b1; redirect_pc = 32'h100;
        step();
        flush = 1'b0;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL fp_req_hold got %h exp 1", imem_req); end
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL fp_addr_hold got %h exp 8", imem_addr); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL fp_valid got %h exp 0", fetch_valid); end
        checks++; if (instr_out !== 32'h13) begin errors++; $display("FAIL fp_instr got %h exp 13", instr_out); end
        step(); step();
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL fp_addr_hold2 got %h exp 8", imem_addr); end
        imem_ack = 1'b1;
        step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL fp_req_idle got %h exp 0", imem_req); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL fp_discard got %h exp 0", fetch_valid); end
        step();
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL fp_addr_new got %h exp 100", imem_addr); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL fp_req_new got %h exp 1", imem_req); end
        step();
        checks++; if (instr_out !== 32'h1100) begin errors++; $display("FAIL fp_instr_new got %h exp 1100", instr_out); end
        checks++; if (PC_out !== 32'h100) begin errors++; $display("FAIL fp_pc_new got %h exp 100", PC_out); end
    endtask

    task automatic test_flush_ack();
        flush = 1'b1; redirect_pc = 32'h203;
        step();
        flush = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL fa_req got %h exp 0", imem_req); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL fa_valid got %h exp 0", fetch_valid); end
        checks++; if (PC_out !== 32'h0) begin errors++; $display("FAIL fa_pc got %h exp 0", PC_out); end
        step();
        checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL fa_addr got %h exp 200", imem_addr); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL fa_valid2 got %h exp 0", fetch_valid); end
        step();
        checks++; if (instr_out !== 32'h1200) begin errors++; $display("FAIL fa_instr got %h exp 1200", instr_out); end
        checks++; if (PC_out !== 32'h200) begin errors++; $display("FAIL fa_pc_new got %h exp 200", PC_out); end
    endtask

    task automatic test_async_reset();
        imem_ack = 1'b0;
        step();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL ar_req_pre got %h exp 1", imem_req); end
`ifdef IF_PERF_CNT_EN
        checks++; if (fetch_cnt !== 32'd4) begin errors++; $display("FAIL ar_fetch_cnt_pre got %0d exp 4", fetch_cnt); end
        checks++; if (flush_cnt !== 32'd2) begin errors++; $display("FAIL ar_flush_cnt_pre got %0d exp 2", flush_cnt); end
`endif
        #2 reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ar_req got %h exp 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL ar_addr got %h exp 0", imem_addr); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %h exp 0", fetch_valid); end
        checks++; if (instr_out !== 32'h13) begin errors++; $display("FAIL ar_instr got %h exp 13", instr_out); end
`ifdef IF_PERF_CNT_EN
        checks++; if (fetch_cnt !== 32'd0) begin errors++; $display("FAIL ar_fetch_cnt got %0d exp 0", fetch_cnt); end
        checks++; if (flush_cnt !== 32'd0) begin errors++; $display("FAIL ar_flush_cnt got %0d exp 0", flush_cnt); end
`endif
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_zero_word();
        test_flush_pending();
        test_flush_ack();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction fetch stage that drives the IF/ID pipeline register's instr_in/PC_in inputs and honours its stall/flush controls. It generates sequential PCs, runs a single-outstanding request/ack handshake to instruction memory, and buffers returned words in a small FIFO so variable memory latency and downstream stalls are decoupled. On flush it redirects the PC and discards stale buffered and in-flight instructions.

Parameters:
RESET_PC, 32'h00000000, first fetch address after reset
FIFO_DEPTH, 2, instruction buffer entries (power of 2, >=2)
NOP_INSTR, 32'h00000013, instruction presented when no valid fetch (addi x0,x0,0)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
stall  in  1  downstream stall; head entry held, not consumed
flush  in  1  redirect request; discards buffered and in-flight fetches
redirect_pc  in  32  new fetch PC, sampled when flush=1
imem_req  out  1  memory request, registered
imem_addr  out  32  request address, registered, word-aligned
imem_ack  in  1  memory accepts request and returns imem_rdata this cycle
imem_rdata  in  32  instruction word, valid when imem_ack=1
instr_out  out  32  head instruction to IF/ID
PC_out  out  32  PC of head instruction
fetch_valid  out  1  head entry valid

Behaviour:
- Reset (async): imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC, FIFO empty, state IDLE; instr_out=NOP_INSTR, PC_out=0, fetch_valid=0.
- States: IDLE, REQ, DROP. Exactly one request outstanding at most.
- IDLE: if FIFO count < FIFO_DEPTH, next edge -> REQ, imem_req=1, imem_addr=fetch_pc.
- REQ: imem_req and imem_addr held stable until imem_ack sampled high. On ack (no flush): push {imem_addr, imem_rdata} into FIFO, fetch_pc += 4 (32-bit wrap); if count_next < FIFO_DEPTH stay REQ with imem_addr=new fetch_pc (1 fetch/cycle with zero-wait memory), else -> IDLE with imem_req=0. count_next = count + push - pop.
- imem_rdata==0 is stored as NOP_INSTR.
- Output: combinational from FIFO head; empty -> instr_out=NOP_INSTR, PC_out=0, fetch_valid=0. Pop when fetch_valid=1 and stall=0. Push and pop may occur in the same cycle; a push into a full FIFO never happens.
- Latency: data acked at edge N is visible on instr_out after edge N (first cycle following ack).
- Flush (priority over stall, ack, pop): FIFO cleared, fetch_pc <= {redirect_pc[31:2],2'b00}.
  - in IDLE, or in REQ with imem_ack=1 same cycle: acked data discarded, -> IDLE, then new request next edge.
  - in REQ with imem_ack=0: -> DROP; imem_req/imem_addr stay on the old request (handshake never abandoned).
  - DROP: on ack, data discarded, -> IDLE. A further flush in DROP updates fetch_pc only.
- Outputs show NOP_INSTR/fetch_valid=0 from the edge after flush until fresh data arrives.
- Reset mid-transaction: request dropped immediately; imem is on the same reset.

Optional Feature:
IF_PERF_CNT_EN: when defined, adds outputs fetch_cnt[31:0] (acks pushed into FIFO, excluding discarded) and flush_cnt[31:0] (cycles with flush=1); both reset to 0 and wrap at 2^32. When undefined, the ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
- Reset release, imem_ack=1 always, rdata=addr+0x1000, stall=0 -> imem_addr 0,4,8,... per cycle; instr_out 0x1000/PC_out 0 one cycle after first ack, then 0x1004/4.
- stall=1 for 4 cycles, DEPTH=2 -> FIFO fills, imem_req drops to 0, instr_out/PC_out hold; stall=0 -> entries consume in order, requests resume at the next PC.
- Request to 0x8 pending (ack delayed 3 cycles), flush with redirect_pc=0x100 -> imem_addr holds 0x8 until ack, data discarded, next request 0x100; instr_out=0x13, fetch_valid=0 in between.
- flush and imem_ack in the same cycle, redirect_pc=0x203 -> acked word not output; next imem_addr=0x200.
- imem_rdata=0 at PC 0x10 -> instr_out=0x00000013, PC_out=0x10, fetch_valid=1.
- reset asserted mid-REQ (async, between edges) -> imem_req=0 and imem_addr=RESET_PC immediately; with IF_PERF_CNT_EN, fetch_cnt=0 and flush_cnt=0.
